// File: rtl/fetch_unit_if.sv
// Purpose : fetch-stage bundle: instruction-memory handshake, decode-facing fields, retire/control-flow inputs.
// Latency : n/a (wires only).
// Backpressure: imem_ready stalls FETCH; retire stalls EXEC.
// Ports   : master = fetch unit (drives imem_req/addr, instr fields, pc, status);
//           slave  = memory + datapath side (drives imem_ready/rdata, retire, control-flow inputs).
interface fetch_unit_if;
    // instruction memory
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    // decode-facing
    logic [31:0] instr;
    logic        instr_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    // retire / control flow
    logic        retire;
    logic        branch;
    logic        branch_taken;
    logic        jal;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] alu_result;
    // status
    logic        misalign_fault;
    logic [31:0] instret;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, opcode, funct3,
               pc, pc_plus4, misalign_fault, instret,
        input  imem_ready, imem_rdata, retire, branch, branch_taken,
               jal, jalr, imm, alu_result
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, opcode, funct3,
               pc, pc_plus4, misalign_fault, instret,
        output imem_ready, imem_rdata, retire, branch, branch_taken,
               jal, jalr, imm, alu_result
    );
endinterface

// File: rtl/fetch_unit.sv
// Purpose : RV32I fetch/PC stage: fetches one word per instruction, holds it for decode, advances PC on retire.
// Latency : instr_valid one cycle after the imem_req & imem_ready edge; new PC/imem_req one cycle after retire.
// Backpressure: holds FETCH (address stable) until imem_ready; holds EXEC (instr stable) until retire.
// Ports   : clk, rst (sync, active-high); bus = fetch_unit_if.master carrying imem handshake,
//           latched instr/opcode/funct3/pc/pc_plus4, retire + branch/jal/jalr controls, misalign_fault, instret.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_EXEC,
        S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] next_pc;
    logic        target_misaligned;

    // Target selection: jalr beats jal/taken-branch beats sequential.
    always_comb begin
        next_pc = pc_q + 32'd4;
        if (bus.jalr) begin
            next_pc = bus.alu_result & ~32'h1;
        end else if (bus.jal || (bus.branch && bus.branch_taken)) begin
            next_pc = pc_q + bus.imm;
        end
        // bit 0 already cleared for jalr, so a jalr fault can only come from bit 1
        target_misaligned = (next_pc[1:0] != 2'b00);
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        unique case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ready) begin
                    instr_d = bus.imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.retire) begin
                    if (target_misaligned) begin
                        // pc stays on the faulting instruction; it is not counted
                        state_d = S_FAULT;
                    end else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RESET;
            pc_q      <= RESET_PC;
            instr_q   <= NOP;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
        end
    end

    // All outputs decode straight from registered state, so they are glitch-free per cycle.
    assign bus.imem_req       = (state_q == S_FETCH);
    assign bus.imem_addr      = pc_q;
    assign bus.instr          = instr_q;
    assign bus.instr_valid    = (state_q == S_EXEC);
    assign bus.opcode         = instr_q[6:0];
    assign bus.funct3         = instr_q[14:12];
    assign bus.pc             = pc_q;
    assign bus.pc_plus4       = pc_q + 32'd4;
    assign bus.misalign_fault = (state_q == S_FAULT);
    assign bus.instret        = instret_q;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter stage for the RV32I core. It sits directly upstream of the opcode decoder. It owns the PC register and fetches one 32-bit word at a time from instruction memory over a req/ready handshake. It presents the latched instruction and its opcode/funct3 fields to decode, then computes the next PC from the branch/jal/jalr outcome when the datapath retires the instruction. It also flags misaligned control-flow targets and counts retired instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_ready` in 1: memory has `imem_rdata` valid this cycle.
- `imem_rdata` in 32: fetched instruction word.
- `instr` out 32: latched instruction.
- `instr_valid` out 1: `instr` is valid and awaiting retire.
- `opcode` out 7: `instr[6:0]`, feeds the decoder.
- `funct3` out 3: `instr[14:12]`, feeds the decoder.
- `pc` out 32: address of the current instruction.
- `pc_plus4` out 32: `pc + 4`, used for jal/jalr link writeback.
- `retire` in 1: datapath has completed the current instruction; PC may advance.
- `branch` in 1: current instruction is a conditional branch.
- `branch_taken` in 1: branch condition evaluated true.
- `jal` in 1: current instruction is JAL.
- `jalr` in 1: current instruction is JALR.
- `imm` in 32: sign-extended immediate (B/J offset).
- `alu_result` in 32: rs1 + imm, the JALR target.
- `misalign_fault` out 1: sticky; a control-flow target was not word aligned.
- `instret` out 32: retired-instruction counter.

## Operation
- States are RESET, FETCH, EXEC and FAULT.
  - RESET: only during `rst`.
  - RESET → FETCH: the first cycle after `rst` deasserts.
  - FETCH: `imem_req` = 1. On `imem_ready` = 1, latch `imem_rdata` into `instr` and go to EXEC. Otherwise hold with the address stable.
  - EXEC: `instr_valid` = 1. `retire` = 0 means hold. `retire` = 1 means compute `next_pc`.
    - If the target is aligned, load `pc ← next_pc`, increment `instret`, and go to FETCH.
    - If the target is misaligned, go to FAULT.
  - FAULT: `misalign_fault` = 1, `imem_req` = 0, `instr_valid` = 0. `pc` holds the faulting instruction's address. Exit only via `rst`.
- next_pc is chosen in this priority order:
  1. `jalr`: `(alu_result & ~32'h1)`.
  2. `jal`, or `branch & branch_taken`: `pc + imm`.
  3. Otherwise: `pc + 4`.
- Misaligned means `next_pc[1:0] != 2'b00`, checked after the jalr bit-0 clear. pc+4 can never fault.
- All PC arithmetic is modulo 2^32 and wraps silently, e.g. 32'hFFFF_FFFC + 4 = 0.
- `instret` wraps from 32'hFFFF_FFFF to 0. A faulting instruction is not counted.
- `retire` is ignored outside EXEC. `imem_ready` is ignored outside FETCH.
- `branch` with `branch_taken` = 0 selects pc+4.

## Timing
- Reset values:
  - `pc` = RESET_PC, `instr` = 32'h0000_0013 (NOP), `instr_valid` = 0.
  - `imem_req` = 0, `misalign_fault` = 0, `instret` = 0.
  - `opcode` = 7'h13 and `funct3` = 0, derived from `instr`.
- `imem_req` first rises in the cycle after `rst` deasserts.
- Fetch latency: `instr_valid` rises the cycle after the edge where `imem_req & imem_ready`. Zero-wait memory gives 1 cycle.
- Minimum throughput is 2 cycles per instruction: one FETCH cycle plus one EXEC cycle with `retire` = 1.
- `imem_rdata` is sampled only in a cycle where `imem_ready` = 1.
- `retire` sampled at edge N: the new `pc`, `imem_req` = 1 and `instr_valid` = 0 are all visible after edge N.
- `instr`, `pc` and the derived fields are stable for the whole EXEC state.
- `rst` during FETCH or EXEC wins over everything. An in-flight fetch is abandoned and `imem_req` is 0 after the reset edge. Any late `imem_ready` is ignored until the new FETCH.
- `rst` wins over a simultaneous `retire`: no PC update and no `instret` increment.

## Test plan
- **Reset and sequential fetch:** RESET_PC = 0, memory holds 4 ADDI words, zero-wait, `retire` pulsed in every EXEC → `imem_addr` sequence 0, 4, 8, 12. `instret` = 4 after the fourth retire. `instr_valid` is high in exactly one cycle per instruction.
- **Wait states:** `imem_ready` delayed 3 cycles at pc = 8 → `imem_addr` = 8 held for 4 cycles with `imem_req` = 1, and `instr_valid` stays 0 until the cycle after ready.
- **Branch:** pc = 0x20, imm = -16.
  - `branch` = 1, `branch_taken` = 1 → next pc = 0x10.
  - `branch` = 1, `branch_taken` = 0 → next pc = 0x24.
- **JAL/JALR:** pc = 0x40.
  - `jal`, imm = 0x100 → pc = 0x140, and `pc_plus4` read 0x44 before retire.
  - `jalr`, alu_result = 0x201 → pc = 0x200, no fault.
- **Misalign fault:** `jal`, pc = 0x40, imm = 0x6 → `misalign_fault` = 1 the cycle after retire, `pc` stays 0x40, `instret` unchanged, `imem_req` stays 0 until `rst`.
- **Reset mid-operation and wrap:**
  - Assert `rst` in FETCH with `imem_ready` = 1 → `instr` is NOP, `pc` = RESET_PC, no increment.
  - pc = 0xFFFF_FFFC with a plain retire → pc wraps to 0.
